// File: rtl/mastermind_pkg.sv
// Shared constants, FSM encoding and score payload for the Mastermind scoreboard.
package mastermind_pkg;

   localparam int unsigned PEGS_DEF        = 4;
   localparam int unsigned MAX_GUESSES_DEF = 8;
   localparam int unsigned COLOUR_W        = 3;
   localparam int unsigned COUNT_W         = 3;
   localparam int unsigned GCNT_W          = 4;
   localparam int unsigned IDX_W           = 3;

   typedef enum logic [1:0] {
      ST_PLAYING = 2'd0,
      ST_WON     = 2'd1,
      ST_LOST    = 2'd2
   } state_e;

   typedef struct packed {
      logic [COUNT_W-1:0] red;
      logic [COUNT_W-1:0] white;
   } score_t;

   // A score is impossible if it claims more matches than there are pegs.
   function automatic logic score_malformed(input logic [COUNT_W-1:0] red,
                                            input logic [COUNT_W-1:0] white,
                                            input int unsigned        pegs);
      logic [GCNT_W-1:0] sum;
      sum = GCNT_W'(red) + GCNT_W'(white);
      return (sum > GCNT_W'(pegs)) || (GCNT_W'(red) > GCNT_W'(pegs));
   endfunction

endpackage

// File: rtl/mastermind_history.sv
// Guess history register file: one synchronous write port, one registered read
// port with a synchronous clear so empty history always reads as zero.
module mastermind_history
   import mastermind_pkg::*;
#(
   parameter int unsigned DEPTH = MAX_GUESSES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  score_t           wr_data,
   input  logic [IDX_W-1:0] rd_addr,
   input  logic             rd_clr,
   output score_t           rd_data
);

   score_t mem_q [DEPTH];
   score_t rd_q;

   // Storage is deliberately unreset; unrecorded slots are never addressed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else if (rd_clr) begin
         rd_q <= '0;
      end else begin
         rd_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/mastermind_scoreboard.sv
// Mastermind game scoreboard: records scored guesses, decides win/loss and
// lets the player browse the guess history.
module mastermind_scoreboard
   import mastermind_pkg::*;
#(
   parameter int unsigned PEGS        = PEGS_DEF,
   parameter int unsigned MAX_GUESSES = MAX_GUESSES_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               new_game,
   input  logic               result_valid,
   input  logic [COUNT_W-1:0] red,
   input  logic [COUNT_W-1:0] white,
   input  logic               browse,
   output logic               guess_accept,
   output logic               won,
   output logic               lost,
   output logic [GCNT_W-1:0]  guesses_used,
   output logic [IDX_W-1:0]   disp_index,
   output logic [COUNT_W-1:0] disp_red,
   output logic [COUNT_W-1:0] disp_white,
   output logic               err
);

   state_e            state_q, state_d;
   logic [GCNT_W-1:0] used_q, used_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              err_q, err_d;
   logic              accept_q, won_q, lost_q;

   logic              playing_c;
   logic              malformed_c;
   logic              accept_c;
   logic              last_slot_c;
   logic              wr_en_c;
   logic              rd_clr_c;
   score_t            wr_data_c;
   score_t            rd_data;

   // Next-state and bookkeeping; new_game overrides every other pulse.
   always_comb begin
      state_d     = state_q;
      used_d      = used_q;
      idx_d       = idx_q;
      err_d       = err_q;
      wr_en_c     = 1'b0;
      wr_data_c   = '{red: red, white: white};
      playing_c   = (state_q == ST_PLAYING);
      malformed_c = score_malformed(red, white, PEGS);
      accept_c    = result_valid && playing_c && !malformed_c &&
                    (used_q < GCNT_W'(MAX_GUESSES));
      last_slot_c = (GCNT_W'(idx_q) == (used_q - GCNT_W'(1)));
      rd_clr_c    = new_game || (used_q == '0);

      if (new_game) begin
         state_d = ST_PLAYING;
         used_d  = '0;
         idx_d   = '0;
         err_d   = 1'b0;
      end else if (accept_c) begin
         wr_en_c = 1'b1;
         used_d  = used_q + GCNT_W'(1);
         idx_d   = IDX_W'(used_q);
         // A win on the final guess beats running out of guesses.
         if (red == COUNT_W'(PEGS)) begin
            state_d = ST_WON;
         end else if (used_d == GCNT_W'(MAX_GUESSES)) begin
            state_d = ST_LOST;
         end
      end else begin
         if (result_valid && playing_c && malformed_c) begin
            err_d = 1'b1;
         end
         if (browse && (used_q != '0)) begin
            idx_d = last_slot_c ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_PLAYING;
         used_q   <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         accept_q <= 1'b1;
         won_q    <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         used_q   <= used_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
         accept_q <= (state_d == ST_PLAYING);
         won_q    <= (state_d == ST_WON);
         lost_q   <= (state_d == ST_LOST);
      end
   end

   mastermind_history #(
      .DEPTH (MAX_GUESSES)
   ) u_history (
      .clk     (clk),
      .rst_n   (resetn),
      .wr_en   (wr_en_c),
      .wr_addr (IDX_W'(used_q)),
      .wr_data (wr_data_c),
      .rd_addr (idx_q),
      .rd_clr  (rd_clr_c),
      .rd_data (rd_data)
   );

   assign guess_accept = accept_q;
   assign won          = won_q;
   assign lost         = lost_q;
   assign guesses_used = used_q;
   assign disp_index   = idx_q;
   assign disp_red     = rd_data.red;
   assign disp_white   = rd_data.white;
   assign err          = err_q;

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Directed self-checking bench for mastermind_scoreboard.
module tb_mastermind_scoreboard;

   logic       clk;
   logic       resetn;
   logic       new_game;
   logic       result_valid;
   logic [2:0] red;
   logic [2:0] white;
   logic       browse;
   logic       guess_accept;
   logic       won;
   logic       lost;
   logic [3:0] guesses_used;
   logic [2:0] disp_index;
   logic [2:0] disp_red;
   logic [2:0] disp_white;
   logic       err;

   int checks = 0;
   int errors = 0;

   mastermind_scoreboard dut (
      .clk          (clk),
      .resetn       (resetn),
      .new_game     (new_game),
      .result_valid (result_valid),
      .red          (red),
      .white        (white),
      .browse       (browse),
      .guess_accept (guess_accept),
      .won          (won),
      .lost         (lost),
      .guesses_used (guesses_used),
      .disp_index   (disp_index),
      .disp_red     (disp_red),
      .disp_white   (disp_white),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of pulses starting just after a rising edge; returns
   // just after the edge that registers them.
   task automatic cycle(input logic ng, input logic rv, input int r, input int w, input logic br);
      new_game     = ng;
      result_valid = rv;
      red          = 3'(r);
      white        = 3'(w);
      browse       = br;
      @(posedge clk);
      #1;
      new_game     = 1'b0;
      result_valid = 1'b0;
      red          = 3'd0;
      white        = 3'd0;
      browse       = 1'b0;
   endtask

   task automatic result(input int r, input int w);
      cycle(1'b0, 1'b1, r, w, 1'b0);
   endtask

   task automatic do_browse();
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic start_game();
      cycle(1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic check_status(input string tag, input int ga, input int wn, input int ls,
                               input int used, input int e);
      check({tag, ".guess_accept"}, int'(guess_accept), ga);
      check({tag, ".won"},          int'(won),          wn);
      check({tag, ".lost"},         int'(lost),         ls);
      check({tag, ".guesses_used"}, int'(guesses_used), used);
      check({tag, ".err"},          int'(err),          e);
   endtask

   task automatic check_disp(input string tag, input int idx, input int r, input int w);
      check({tag, ".disp_index"}, int'(disp_index), idx);
      check({tag, ".disp_red"},   int'(disp_red),   r);
      check({tag, ".disp_white"}, int'(disp_white), w);
   endtask

   int exp_idx [4] = '{0, 1, 2, 0};
   int exp_r   [3] = '{1, 2, 4};
   int exp_w   [3] = '{2, 1, 0};

   initial begin
      resetn = 1'b0; new_game = 1'b0; result_valid = 1'b0;
      red = 3'd0; white = 3'd0; browse = 1'b0;
      #12;
      check_status("reset", 1, 0, 0, 0, 0);
      check_disp("reset", 0, 0, 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Three results ending in a win; a later result is ignored.
      result(1, 2); result(2, 1); result(4, 0);
      check_status("win3", 0, 1, 0, 3, 0);
      check("win3.idx", int'(disp_index), 2);
      idle();
      check_disp("win3.view", 2, 4, 0);
      result(1, 1);
      check_status("win3.ignored", 0, 1, 0, 3, 0);
      check_disp("win3.ignored", 2, 4, 0);

      // History browse in WON state: 0,1,2,0 with the recorded scores.
      for (int i = 0; i < 4; i++) begin
         do_browse();
         check("browse.idx", int'(disp_index), exp_idx[i]);
         idle();
         check("browse.red",   int'(disp_red),   exp_r[exp_idx[i]]);
         check("browse.white", int'(disp_white), exp_w[exp_idx[i]]);
      end

      // new_game returns everything to reset values.
      start_game();
      check_status("newgame", 1, 0, 0, 0, 0);
      check_disp("newgame", 0, 0, 0);
      do_browse();
      idle();
      check_disp("browse_empty", 0, 0, 0);

      // Eight non-winning guesses lose; guesses_used stays at 8.
      for (int i = 0; i < 7; i++) result(1, 1);
      check_status("loss7", 1, 0, 0, 7, 0);
      result(1, 1);
      check_status("loss8", 0, 0, 1, 8, 0);
      result(4, 0);
      check_status("loss.ignored", 0, 0, 1, 8, 0);
      do_browse();
      check("loss.browse_wrap", int'(disp_index), 0);

      // Win on the eighth guess beats the loss.
      start_game();
      for (int i = 0; i < 7; i++) result(1, 1);
      result(4, 0);
      check_status("win8", 0, 1, 0, 8, 0);

      // Malformed results set a sticky err without recording.
      start_game();
      result(1, 0);
      result(3, 2);
      check_status("malformed_sum", 1, 0, 0, 1, 1);
      result(5, 0);
      check_status("malformed_red", 1, 0, 0, 1, 1);
      result(2, 2);
      check_status("sum_eq_pegs", 1, 0, 0, 2, 1);
      check("sum_eq_pegs.idx", int'(disp_index), 1);
      do_browse();
      check("browse_play.idx", int'(disp_index), 0);

      // Browse coincident with an accepted result: result slot shown.
      cycle(1'b0, 1'b1, 0, 3, 1'b1);
      check_status("browse_vs_result", 1, 0, 0, 3, 1);
      check("browse_vs_result.idx", int'(disp_index), 2);
      idle();
      check_disp("browse_vs_result", 2, 0, 3);

      // new_game beats a coincident winning result.
      cycle(1'b1, 1'b1, 4, 0, 1'b0);
      check_status("ng_vs_result", 1, 0, 0, 0, 0);
      check_disp("ng_vs_result", 0, 0, 0);

      // Asynchronous reset between edges mid-game.
      result(2, 0); result(4, 0);
      idle();
      check_status("pre_async", 0, 1, 0, 2, 0);
      #2 resetn = 1'b0;
      #1;
      check_status("async_rst", 1, 0, 0, 0, 0);
      check_disp("async_rst", 0, 0, 0);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
      result(0, 1);
      check_status("post_rst", 1, 0, 0, 1, 0);
      idle();
      check_disp("post_rst", 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mastermind_scoreboard.md
MASTERMIND_SCOREBOARD -- requirements
Module: mastermind_scoreboard

Interface
REQ-001 Parameter PEGS, default 4: pegs per code; a win is red == PEGS.
REQ-002 Parameter MAX_GUESSES, default 8: guesses per game before loss.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 new_game  input  1  single-cycle pulse; starts a new game.
REQ-007 result_valid  input  1  single-cycle pulse from the scoring datapath; red and white are valid this cycle.
REQ-008 red  input  3  count of exact-position matches.
REQ-009 white  input  3  count of colour-only matches.
REQ-010 browse  input  1  single-cycle pulse; advances the history view.
REQ-011 guess_accept  output  1  high while state is PLAYING; upstream may load guesses.
REQ-012 won  output  1  high in state WON.
REQ-013 lost  output  1  high in state LOST.
REQ-014 guesses_used  output  4  recorded guesses, 0..MAX_GUESSES.
REQ-015 disp_index  output  3  history slot currently shown.
REQ-016 disp_red, disp_white  output  3 each  red/white of the shown slot.
REQ-017 err  output  1  sticky flag: a malformed result was received.

Function
REQ-018 FSM states: PLAYING, WON, LOST; all outputs registered.
REQ-019 Accepted result: result_valid in PLAYING with red+white <= PEGS (4-bit sum, no overflow).
- Writes {red,white} to history[guesses_used].
- Increments guesses_used.
- Sets disp_index to the new slot.
- All updates visible the cycle after the pulse.
REQ-020 Same accepted pulse, state transition:
- red == PEGS -> WON.
- Else, new guesses_used == MAX_GUESSES -> LOST.
- Else stay PLAYING.
- Win takes priority on the final guess.
REQ-021 Malformed result (red+white > PEGS, or red > PEGS) in PLAYING: not recorded, counter and state unchanged; err set.
REQ-022 result_valid in WON or LOST is ignored entirely.
REQ-023 browse with guesses_used > 0: disp_index increments, wrapping from guesses_used-1 to 0; with guesses_used == 0 it is ignored.
REQ-024 browse is honoured in every state.
REQ-025 browse and accepted result_valid in the same cycle: result wins; disp_index = new slot.
REQ-026 disp_red/disp_white equal history[disp_index] one cycle after disp_index changes; both read 0 while guesses_used == 0.
REQ-027 new_game, in any state: next cycle all outputs equal reset values; history need not be cleared, but unrecorded slots are never displayed.
REQ-028 new_game with result_valid or browse in the same cycle: new_game wins; other pulses dropped.
REQ-029 guesses_used saturates at MAX_GUESSES and never wraps.

Reset
REQ-030 On resetn low, asynchronously:
- State = PLAYING; guess_accept = 1.
- won = lost = err = 0.
- guesses_used = 0; disp_index = 0; disp_red = disp_white = 0.
REQ-031 Reset mid-game discards all progress; operation resumes on the first clk edge after resetn rises.

Structure
REQ-032 Shared package mastermind_pkg holds:
- PEGS and MAX_GUESSES defaults.
- Colour width (3) and count width (3).
- FSM state encoding.
REQ-033 One sub-module, mastermind_history: MAX_GUESSES x 6-bit register file, one synchronous write port, one registered read port; no reset on storage.

Verification
REQ-034 Results (1,2), (2,1), (4,0) -> guesses_used=3, won=1, guess_accept=0; a further result_valid leaves everything unchanged.
REQ-035 Eight results of (1,1) -> after 8th lost=1, guesses_used=8; 8th as (4,0) instead -> won=1, lost=0.
REQ-036 Three results recorded, then browse x4 -> disp_index sequence 0,1,2,0 with matching disp_red/disp_white.
REQ-037 Result (3,2) -> err=1, guesses_used unchanged; err persists until new_game or reset.
REQ-038 new_game coincident with result_valid (4,0) -> state PLAYING, guesses_used=0, won=0.
REQ-039 resetn pulsed low between clk edges mid-game -> outputs reach reset values before the next edge.
